// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared constants, enums and geometry helpers for the snake game controller
package snake_pkg;

  // Playfield and sprite geometry
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int BORDER      = 3;
  localparam int SNAKE_HALF  = 10;
  localparam int FOOD_HALF   = 3;
  localparam int FOOD_MARGIN = 20;

  // Legal head-centre box: inside the border by a full snake half-size
  localparam logic [9:0] HEAD_MIN   = 10'(BORDER + SNAKE_HALF);
  localparam logic [9:0] HEAD_MAX_X = 10'(SCREEN_W - 1 - BORDER - SNAKE_HALF);
  localparam logic [9:0] HEAD_MAX_Y = 10'(SCREEN_H - 1 - BORDER - SNAKE_HALF);

  // Fresh food is kept clear of the border by a fixed margin
  localparam logic [9:0] FOOD_MIN   = 10'(FOOD_MARGIN);
  localparam logic [9:0] FOOD_MAX_X = 10'(SCREEN_W - 1 - FOOD_MARGIN);
  localparam logic [9:0] FOOD_MAX_Y = 10'(SCREEN_H - 1 - FOOD_MARGIN);

  // Head and food touch when centres are closer than the sum of half-sizes
  localparam logic [9:0] OVERLAP_LIM = 10'(SNAKE_HALF + FOOD_HALF);

  localparam logic [9:0] INIT_X   = 10'd320;
  localparam logic [9:0] INIT_Y   = 10'd240;
  localparam logic [9:0] F_INIT_X = 10'd100;
  localparam logic [9:0] F_INIT_Y = 10'd100;
  localparam logic [9:0] F_ALT_X  = 10'd540;
  localparam logic [9:0] F_ALT_Y  = 10'd380;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Opposite directions differ only in bit 0
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_MOVE    = 3'd2,
    S_CHECK   = 3'd3,
    S_RESPAWN = 3'd4,
    S_OVER    = 3'd5
  } state_t;

  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic overlaps(input logic [9:0] ax, input logic [9:0] ay,
                                    input logic [9:0] bx, input logic [9:0] by);
    return (abs_diff(ax, bx) < OVERLAP_LIM) && (abs_diff(ay, by) < OVERLAP_LIM);
  endfunction

  function automatic logic is_opposite(input dir_t a, input dir_t b);
    logic [1:0] ra;
    logic [1:0] rb;
    ra = a;
    rb = b;
    return (ra[1] == rb[1]) && (ra[0] != rb[0]);
  endfunction

endpackage

// File: rtl/snake_lfsr16.sv
// rtl/snake_lfsr16.sv - free-running 16-bit Fibonacci LFSR used for food placement
module snake_lfsr16
  import snake_pkg::*;
(
  input  logic        vga_clk,
  input  logic        reset,
  output logic [15:0] lfsr
);

  logic feedback;

  // Taps x^16 + x^14 + x^13 + x^11 + 1
  assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Advance every cycle; the zero guard reseeds should the register ever be upset into the lock-up state
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (lfsr == 16'd0) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], feedback};
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// rtl/snake_game_ctrl.sv - snake head movement, food collision, scoring and respawn state machine
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int STEP_DIV  = 4,
  parameter int STEP      = 2,
  parameter int RETRY_MAX = 64
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  output logic [9:0] snake_x,
  output logic [9:0] snake_y,
  output logic [9:0] food_x,
  output logic [9:0] food_y,
  output logic [7:0] score,
  output logic       running,
  output logic       game_over
);

  localparam int          RW         = (RETRY_MAX < 2) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_MAX);
  localparam logic [3:0]  FC_LAST    = 4'(STEP_DIV - 1);
  localparam logic [10:0] STEP11     = 11'(STEP);

  // Button synchronizers, bit order {up, down, left, right}
  logic [3:0] btn_meta;
  logic [3:0] btn_sync;
  logic [3:0] pressed;
  logic       any_press;

  logic [15:0] lfsr;

  state_t        state;
  dir_t          dir;
  logic [3:0]    frame_cnt;
  logic          move_pending;
  logic [RW-1:0] retry_cnt;

  logic          counting;
  logic          tick_wrap;
  dir_t          want_dir;
  logic          want_valid;
  logic [10:0]   nx;
  logic [10:0]   ny;
  logic          next_legal;
  logic [9:0]    cand_x;
  logic [9:0]    cand_y;
  logic          cand_ok;

  // Two-flop synchronizer; idle level of the active-low buttons is 1
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      btn_meta <= 4'hF;
      btn_sync <= 4'hF;
    end else begin
      btn_meta <= {up, down, left, right};
      btn_sync <= btn_meta;
    end
  end

  assign pressed   = ~btn_sync;
  assign any_press = |pressed;

  snake_lfsr16 u_lfsr (
    .vga_clk (vga_clk),
    .reset   (reset),
    .lfsr    (lfsr)
  );

  assign counting  = (state == S_RUN) || (state == S_MOVE) ||
                     (state == S_CHECK) || (state == S_RESPAWN);
  assign tick_wrap = counting && frame_tick && (frame_cnt == FC_LAST);

  // Highest-priority pressed button: up > down > left > right
  always_comb begin
    want_valid = 1'b1;
    want_dir   = DIR_RIGHT;
    if (pressed[3]) begin
      want_dir = DIR_UP;
    end else if (pressed[2]) begin
      want_dir = DIR_DOWN;
    end else if (pressed[1]) begin
      want_dir = DIR_LEFT;
    end else if (pressed[0]) begin
      want_dir = DIR_RIGHT;
    end else begin
      want_valid = 1'b0;
    end
  end

  // Candidate head one step ahead; 11-bit math makes an underflow land far outside the box
  always_comb begin
    nx = {1'b0, snake_x};
    ny = {1'b0, snake_y};
    case (dir)
      DIR_UP:    ny = {1'b0, snake_y} - STEP11;
      DIR_DOWN:  ny = {1'b0, snake_y} + STEP11;
      DIR_LEFT:  nx = {1'b0, snake_x} - STEP11;
      default:   nx = {1'b0, snake_x} + STEP11;
    endcase
    next_legal = (nx >= {1'b0, HEAD_MIN}) && (nx <= {1'b0, HEAD_MAX_X}) &&
                 (ny >= {1'b0, HEAD_MIN}) && (ny <= {1'b0, HEAD_MAX_Y});
  end

  assign cand_x  = lfsr[9:0];
  assign cand_y  = {1'b0, lfsr[15:7]};
  assign cand_ok = (cand_x >= FOOD_MIN) && (cand_x <= FOOD_MAX_X) &&
                   (cand_y >= FOOD_MIN) && (cand_y <= FOOD_MAX_Y) &&
                   !overlaps(snake_x, snake_y, cand_x, cand_y);

  // Game state machine with all outputs registered
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state        <= S_IDLE;
      snake_x      <= INIT_X;
      snake_y      <= INIT_Y;
      food_x       <= F_INIT_X;
      food_y       <= F_INIT_Y;
      score        <= 8'd0;
      dir          <= DIR_RIGHT;
      frame_cnt    <= 4'd0;
      move_pending <= 1'b0;
      retry_cnt    <= '0;
      running      <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      if (counting && frame_tick) begin
        frame_cnt <= (frame_cnt == FC_LAST) ? 4'd0 : frame_cnt + 4'd1;
      end

      case (state)
        S_IDLE: begin
          if (any_press) begin
            state   <= S_RUN;
            running <= 1'b1;
          end
        end

        S_RUN: begin
          if (want_valid && !is_opposite(want_dir, dir)) begin
            dir <= want_dir;
          end
          if (move_pending) begin
            state <= S_MOVE;
          end
        end

        S_MOVE: begin
          move_pending <= 1'b0;
          if (next_legal) begin
            snake_x <= nx[9:0];
            snake_y <= ny[9:0];
            state   <= S_CHECK;
          end else begin
            state     <= S_OVER;
            running   <= 1'b0;
            game_over <= 1'b1;
          end
        end

        S_CHECK: begin
          if (overlaps(snake_x, snake_y, food_x, food_y)) begin
            if (score != 8'hFF) begin
              score <= score + 8'd1;
            end
            retry_cnt <= '0;
            state     <= S_RESPAWN;
          end else begin
            state <= S_RUN;
          end
        end

        S_RESPAWN: begin
          if (retry_cnt == RETRY_LAST) begin
            if (overlaps(snake_x, snake_y, F_INIT_X, F_INIT_Y)) begin
              food_x <= F_ALT_X;
              food_y <= F_ALT_Y;
            end else begin
              food_x <= F_INIT_X;
              food_y <= F_INIT_Y;
            end
            state <= S_RUN;
          end else if (cand_ok) begin
            food_x <= cand_x;
            food_y <= cand_y;
            state  <= S_RUN;
          end else begin
            retry_cnt <= retry_cnt + RW'(1);
          end
        end

        S_OVER: begin
          if (frame_tick && !any_press) begin
            state        <= S_IDLE;
            snake_x      <= INIT_X;
            snake_y      <= INIT_Y;
            food_x       <= F_INIT_X;
            food_y       <= F_INIT_Y;
            score        <= 8'd0;
            dir          <= DIR_RIGHT;
            frame_cnt    <= 4'd0;
            move_pending <= 1'b0;
            game_over    <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase

      // A wrap landing on the MOVE cycle must survive MOVE's clear
      if (tick_wrap) begin
        move_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb/tb_snake_game_ctrl.sv - directed self-checking bench for snake_game_ctrl
module tb_snake_game_ctrl;
  import snake_pkg::*;

  logic       vga_clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       up = 1'b1;
  logic       down = 1'b1;
  logic       left = 1'b1;
  logic       right = 1'b1;

  logic [9:0] snake_x, snake_y, food_x, food_y;
  logic [7:0] score;
  logic       running, game_over;

  logic [9:0] fb_snake_x, fb_snake_y, fb_food_x, fb_food_y;
  logic [7:0] fb_score;
  logic       fb_running, fb_game_over;

  int checks = 0;
  int failures = 0;

  always #5 vga_clk = ~vga_clk;

  snake_game_ctrl dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .snake_x    (snake_x),
    .snake_y    (snake_y),
    .food_x     (food_x),
    .food_y     (food_y),
    .score      (score),
    .running    (running),
    .game_over  (game_over)
  );

  snake_game_ctrl #(.RETRY_MAX(0)) dut_fb (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .snake_x    (fb_snake_x),
    .snake_y    (fb_snake_y),
    .food_x     (fb_food_x),
    .food_y     (fb_food_y),
    .score      (fb_score),
    .running    (fb_running),
    .game_over  (fb_game_over)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick_once();
    @(negedge vga_clk);
    frame_tick = 1'b1;
    @(negedge vga_clk);
    frame_tick = 1'b0;
    repeat (8) @(negedge vga_clk);
  endtask

  task automatic moves(input int n);
    for (int i = 0; i < 4 * n; i++) tick_once();
  endtask

  // 0=up 1=down 2=left 3=right
  task automatic press(input int which);
    @(negedge vga_clk);
    case (which)
      0: up = 1'b0;
      1: down = 1'b0;
      2: left = 1'b0;
      default: right = 1'b0;
    endcase
    repeat (5) @(negedge vga_clk);
    up = 1'b1; down = 1'b1; left = 1'b1; right = 1'b1;
    repeat (3) @(negedge vga_clk);
  endtask

  function automatic logic [9:0] adiff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  initial begin
    logic ok;
    logic found;

    // Reset values
    repeat (3) @(negedge vga_clk);
    check("rst_snake_x", 16'(snake_x), 16'd320);
    check("rst_snake_y", 16'(snake_y), 16'd240);
    check("rst_food_x", 16'(food_x), 16'd100);
    check("rst_food_y", 16'(food_y), 16'd100);
    check("rst_score", 16'(score), 16'd0);
    check("rst_running", 16'(running), 16'd0);
    check("rst_game_over", 16'(game_over), 16'd0);
    check("rst_lfsr", dut.u_lfsr.lfsr, 16'hACE1);
    reset = 1'b0;
    repeat (2) @(negedge vga_clk);
    check("idle_running", 16'(running), 16'd0);

    // Start moving right: 8 ticks is two moves
    press(3);
    check("start_running", 16'(running), 16'd1);
    moves(2);
    check("right8_x", 16'(snake_x), 16'd324);
    check("right8_y", 16'(snake_y), 16'd240);
    check("right8_running", 16'(running), 16'd1);

    // Opposite press ignored
    press(2);
    moves(1);
    check("opp_ignored_x", 16'(snake_x), 16'd326);
    check("opp_ignored_y", 16'(snake_y), 16'd240);

    // Turn up
    press(0);
    moves(1);
    check("up_y", 16'(snake_y), 16'd238);
    check("up_x", 16'(snake_x), 16'd326);

    // Approach food at (100,100): up to y=110, left to x=112
    moves(64);
    check("approach_y", 16'(snake_y), 16'd110);
    check("approach_score0", 16'(score), 16'd0);
    press(2);
    moves(106);
    check("pre_eat_x", 16'(snake_x), 16'd114);
    check("pre_eat_score", 16'(score), 16'd0);
    moves(1);
    check("eat_x", 16'(snake_x), 16'd112);
    check("eat_score", 16'(score), 16'd1);
    check("fb_eat_score", 16'(fb_score), 16'd1);
    repeat (70) @(negedge vga_clk);
    ok = (food_x >= 10'd20) && (food_x <= 10'd619) && (food_y >= 10'd20) && (food_y <= 10'd459);
    check("respawn_in_box", 16'(ok), 16'd1);
    ok = (adiff(food_x, snake_x) < 10'd13) && (adiff(food_y, snake_y) < 10'd13);
    check("respawn_clear_of_snake", 16'(ok), 16'd0);
    check("respawn_running", 16'(running), 16'd1);
    // Fallback with snake sitting on (100,100) goes to the alternate spot
    check("fb_alt_x", 16'(fb_food_x), 16'd540);
    check("fb_alt_y", 16'(fb_food_y), 16'd380);

    // Head to (540,380): down to y=368, right to x=528
    press(1);
    moves(129);
    check("down_y", 16'(snake_y), 16'd368);
    press(3);
    moves(208);
    check("fb_eat2_x", 16'(fb_snake_x), 16'd528);
    check("fb_eat2_score", 16'(fb_score), 16'd2);
    check("fb_init_x", 16'(fb_food_x), 16'd100);
    check("fb_init_y", 16'(fb_food_y), 16'd100);

    // Run into the right wall
    moves(49);
    check("wall_x", 16'(snake_x), 16'd626);
    check("wall_running", 16'(running), 16'd1);
    check("wall_game_over0", 16'(game_over), 16'd0);
    moves(1);
    check("over_game_over", 16'(game_over), 16'd1);
    check("over_running", 16'(running), 16'd0);
    check("over_x_held", 16'(snake_x), 16'd626);
    check("over_y_held", 16'(snake_y), 16'd368);
    tick_once();
    check("idle_snake_x", 16'(snake_x), 16'd320);
    check("idle_snake_y", 16'(snake_y), 16'd240);
    check("idle_food_x", 16'(food_x), 16'd100);
    check("idle_food_y", 16'(food_y), 16'd100);
    check("idle_score", 16'(score), 16'd0);
    check("idle_game_over", 16'(game_over), 16'd0);
    check("idle_running2", 16'(running), 16'd0);

    // Eat again and reset inside RESPAWN
    press(0);
    moves(64);
    check("r2_y", 16'(snake_y), 16'd112);
    press(2);
    moves(103);
    check("r2_x", 16'(snake_x), 16'd114);
    repeat (3) tick_once();
    @(negedge vga_clk);
    frame_tick = 1'b1;
    @(negedge vga_clk);
    frame_tick = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (dut.state == S_RESPAWN) begin
        found = 1'b1;
        break;
      end
      @(negedge vga_clk);
    end
    check("reached_respawn", 16'(found), 16'd1);
    reset = 1'b1;
    @(negedge vga_clk);
    check("abort_snake_x", 16'(snake_x), 16'd320);
    check("abort_snake_y", 16'(snake_y), 16'd240);
    check("abort_food_x", 16'(food_x), 16'd100);
    check("abort_food_y", 16'(food_y), 16'd100);
    check("abort_score", 16'(score), 16'd0);
    check("abort_lfsr", dut.u_lfsr.lfsr, 16'hACE1);
    check("abort_running", 16'(running), 16'd0);
    reset = 1'b0;
    repeat (2) @(negedge vga_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snake_game_ctrl.md
SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

Interface
REQ-001 Parameter: STEP_DIV, 4, frame_tick pulses per head move (1..15).
REQ-002 Parameter: STEP, 2, pixels moved per head move.
REQ-003 Parameter: RETRY_MAX, 64, food respawn draws before fallback.
REQ-004 vga_clk  in  1  single clock; one clock only.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 frame_tick  in  1  one-cycle pulse at start of vertical blank.
REQ-007 up, down, left, right  in  1 each  buttons, active-low, asynchronous to vga_clk.
REQ-008 snake_x, snake_y  out  10 each  snake head centre, in pixels.
REQ-009 food_x, food_y  out  10 each  food centre, in pixels.
REQ-010 score  out  8  food eaten count.
REQ-011 running  out  1  high in any state except IDLE and OVER.
REQ-012 game_over  out  1  high in OVER only.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer; pressed = synchronized value 0.
REQ-014 States SHALL be IDLE, RUN, MOVE, CHECK, RESPAWN, OVER; all outputs registered.
REQ-015 On entry to IDLE: snake = (320,240), food = (100,100), score = 0, dir = RIGHT, frame counter = 0, move_pending = 0.
REQ-016 IDLE -> RUN on any synchronized press.
REQ-017 In RUN, dir SHALL take the pressed button with priority up>down>left>right, except that a press opposite to the current dir is ignored.
REQ-018 Frame counter SHALL advance on frame_tick in RUN/MOVE/CHECK/RESPAWN and wrap at STEP_DIV-1; the wrap sets move_pending.
REQ-019 RUN -> MOVE in the cycle move_pending is 1; MOVE clears move_pending.
REQ-020 MOVE: compute head +/- STEP along dir; legal box is x in [13,626] and y in [13,466] (border 3 + half-size 10).
REQ-021 MOVE: if the new head is illegal -> OVER with head unchanged; otherwise update the head and go to CHECK.
REQ-022 CHECK: overlap is |snake_x-food_x| < 13 and |snake_y-food_y| < 13 (unsigned 10-bit difference, no wrap).
REQ-023 CHECK: on overlap, score += 1 saturating at 255, then RESPAWN; otherwise RUN.
REQ-024 RESPAWN: each cycle draw candidate x = lfsr[9:0], y = {1'b0, lfsr[15:7]}.
REQ-025 RESPAWN: accept the candidate when x in [20,619], y in [20,459] and it does not overlap the snake per REQ-022; on accept, update food and go to RUN.
REQ-026 RESPAWN fallback: after RETRY_MAX rejected draws, place food at (100,100); if that overlaps the snake, place it at (540,380) instead; then RUN.
REQ-027 LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1, advancing every cycle in every state; it SHALL never reach zero.
REQ-028 OVER holds all outputs; OVER -> IDLE on a frame_tick with no button pressed.
REQ-029 The MOVE->RESPAWN sequence is at most 3+RETRY_MAX cycles, so all updates complete inside vertical blank.
REQ-030 frame_tick coincident with a MOVE or CHECK exit is still counted; no move is lost.

Reset
REQ-031 reset SHALL force state IDLE with the REQ-015 values, lfsr = 16'hACE1, synchronizer flops = 1, running = 0, game_over = 0.
REQ-032 reset asserted mid-RESPAWN or mid-MOVE SHALL abort it; outputs equal the reset values in the following cycle.

Structure
REQ-033 Package snake_pkg SHALL hold: screen 640x480, BORDER=3, SNAKE_HALF=10, FOOD_HALF=3, INIT and F_INIT coordinates, fallback food coordinate, dir encoding, state enum.
REQ-034 The LFSR SHALL be the sub-module snake_lfsr16 (ports vga_clk, reset, lfsr[15:0]).

Verification
REQ-035 Reset, then press right, then 8 frame_ticks with STEP_DIV=4 -> snake_x = 324, snake_y = 240, running = 1.
REQ-036 dir RIGHT, press left -> dir unchanged; press up then 4 ticks -> snake_y = 238.
REQ-037 Drive head to x = 626, 4 more ticks -> game_over = 1 and snake_x stays 626; release buttons plus 1 tick -> IDLE with reset values.
REQ-038 Steer head to within 12 px of food (100,100) -> score = 1; new food inside [20,619]x[20,459] and not overlapping the snake within 67 cycles.
REQ-039 Force RESPAWN with the LFSR rejecting 64 draws and the snake away from (100,100) -> food = (100,100); repeat with the snake at (100,100) -> food = (540,380).
REQ-040 Assert reset during RESPAWN -> next cycle snake = (320,240), food = (100,100), score = 0, lfsr = 16'hACE1.
